// File: rtl/pc_disp_ctrl_if.sv
// ----------------------------------------------------------------------------
// pc_disp_ctrl_if
// Bus between a program-counter source and the decimal display controller.
//   pc        [31:0] byte program counter (word index pc[17:2] is displayed)
//   upd              update request
//   busy             conversion in progress
//   done             one-cycle pulse when new display values are valid
//   ovf              pc[31:18] was nonzero when the displayed value was captured
//   seg0..seg4 [6:0] active-low abcdefg codes, seg0 = units .. seg4 = 10^4
// master: the side that drives pc/upd; slave: the display controller.
// ----------------------------------------------------------------------------
interface pc_disp_ctrl_if;
    logic [31:0] pc;
    logic        upd;
    logic        busy;
    logic        done;
    logic        ovf;
    logic [6:0]  seg0;
    logic [6:0]  seg1;
    logic [6:0]  seg2;
    logic [6:0]  seg3;
    logic [6:0]  seg4;

    modport master (
        output pc, upd,
        input  busy, done, ovf, seg0, seg1, seg2, seg3, seg4
    );

    modport slave (
        input  pc, upd,
        output busy, done, ovf, seg0, seg1, seg2, seg3, seg4
    );
endinterface

// File: rtl/pc_disp_ctrl.sv
// ----------------------------------------------------------------------------
// pc_disp_ctrl
// Converts the word index pc[17:2] to five decimal digits with a sequential
// shift-add-3 (one bit per clock) and drives five 7-segment displays.
// A conversion starts on an update request, an auto-refresh tick, or a
// request that arrived while a previous conversion was running (pending).
//
// Parameters:
//   AUTO_PERIOD  auto-refresh interval in clk cycles, 0 disables auto-refresh
// Ports:
//   clk          clock, rising edge
//   rst          asynchronous active-high reset
//   bus          pc_disp_ctrl_if.slave (pc, upd in; busy, done, ovf, seg0..4 out)
// Build option:
//   PCDISP_LZB_EN  when defined, seg4..seg1 are blanked while they and all
//                  higher digits are zero; seg0 is never blanked.
// ----------------------------------------------------------------------------
module pc_disp_ctrl #(
    parameter int unsigned AUTO_PERIOD = 50000
) (
    input  logic           clk,
    input  logic           rst,
    pc_disp_ctrl_if.slave  bus
);

    typedef enum logic [1:0] {IDLE, SHIFT, LATCH} state_t;

    state_t      state_reg, state_next;
    logic [15:0] sh_reg, sh_next;
    logic [19:0] bcd_reg, bcd_next;
    logic [15:0] bcd_adj;
    logic [3:0]  bit_reg, bit_next;
    logic        pend_reg, pend_next;
    logic        ovf_cap_reg, ovf_cap_next;
    logic        ovf_reg, ovf_next;
    logic [19:0] dig_reg, dig_next;
    logic        done_reg, done_next;
    logic        tick;
    logic        new_req;
    logic        req;
    logic [6:0]  seg_w [5];
    logic        unused_pc_lsb;

    assign unused_pc_lsb = ^bus.pc[1:0];

    // ---------------- auto-refresh tick ----------------
    generate
        if (AUTO_PERIOD > 0) begin : g_auto
            localparam int CW = (AUTO_PERIOD > 1) ? $clog2(AUTO_PERIOD) : 1;
            localparam logic [CW-1:0] TERM = CW'(AUTO_PERIOD - 1);
            logic [CW-1:0] cnt_reg;

            always_ff @(posedge clk or posedge rst) begin
                if (rst)
                    cnt_reg <= '0;
                else if (cnt_reg == TERM)
                    cnt_reg <= '0;
                else
                    cnt_reg <= cnt_reg + CW'(1);
            end

            assign tick = (cnt_reg == TERM);
        end else begin : g_noauto
            assign tick = 1'b0;
        end
    endgenerate

    // upd and tick in the same cycle are a single request
    assign new_req = bus.upd | tick;
    assign req     = new_req | pend_reg;

    // Add-3 correction for digits 0..3. Digit 4 needs none: with a 16-bit
    // input it is at most 3 before the final shift, so it never reaches 5.
    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_adj
            assign bcd_adj[gi*4 +: 4] = (bcd_reg[gi*4 +: 4] >= 4'd5) ?
                                        bcd_reg[gi*4 +: 4] + 4'd3 :
                                        bcd_reg[gi*4 +: 4];
        end
    endgenerate

    // ---------------- FSM: next state / datapath ----------------
    always_comb begin
        state_next   = state_reg;
        sh_next      = sh_reg;
        bcd_next     = bcd_reg;
        bit_next     = bit_reg;
        pend_next    = pend_reg;
        ovf_cap_next = ovf_cap_reg;
        ovf_next     = ovf_reg;
        dig_next     = dig_reg;
        done_next    = 1'b0;
        case (state_reg)
            IDLE: begin
                if (req) begin
                    sh_next      = bus.pc[17:2];
                    bcd_next     = '0;
                    ovf_cap_next = |bus.pc[31:18];
                    bit_next     = '0;
                    pend_next    = 1'b0;
                    state_next   = SHIFT;
                end
            end
            SHIFT: begin
                pend_next = pend_reg | new_req;
                bcd_next  = {bcd_reg[18:16], bcd_adj, sh_reg[15]};
                sh_next   = {sh_reg[14:0], 1'b0};
                bit_next  = bit_reg + 4'd1;
                if (bit_reg == 4'd15)
                    state_next = LATCH;
            end
            LATCH: begin
                pend_next  = pend_reg | new_req;
                dig_next   = bcd_reg;
                ovf_next   = ovf_cap_reg;
                done_next  = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg   <= IDLE;
            sh_reg      <= '0;
            bcd_reg     <= '0;
            bit_reg     <= '0;
            pend_reg    <= 1'b0;
            ovf_cap_reg <= 1'b0;
            ovf_reg     <= 1'b0;
            dig_reg     <= '0;
            done_reg    <= 1'b0;
        end else begin
            state_reg   <= state_next;
            sh_reg      <= sh_next;
            bcd_reg     <= bcd_next;
            bit_reg     <= bit_next;
            pend_reg    <= pend_next;
            ovf_cap_reg <= ovf_cap_next;
            ovf_reg     <= ovf_next;
            dig_reg     <= dig_next;
            done_reg    <= done_next;
        end
    end

    // ---------------- segment decode ----------------
    function automatic logic [6:0] seg_code(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = 7'b0000001;
            4'd1:    s = 7'b1001111;
            4'd2:    s = 7'b0010010;
            4'd3:    s = 7'b0000110;
            4'd4:    s = 7'b1001100;
            4'd5:    s = 7'b0100100;
            4'd6:    s = 7'b0100000;
            4'd7:    s = 7'b0001111;
            4'd8:    s = 7'b0000000;
            4'd9:    s = 7'b0000100;
            default: s = 7'b1111111;
        endcase
        return s;
    endfunction

    generate
        for (gi = 0; gi < 5; gi++) begin : g_seg
`ifdef PCDISP_LZB_EN
            if (gi == 0) begin : g_units
                assign seg_w[gi] = seg_code(dig_reg[3:0]);
            end else begin : g_lzb
                // blank while this digit and every higher digit are zero
                assign seg_w[gi] = (dig_reg[19:gi*4] == '0) ? 7'b1111111 :
                                   seg_code(dig_reg[gi*4 +: 4]);
            end
`else
            assign seg_w[gi] = seg_code(dig_reg[gi*4 +: 4]);
`endif
        end
    endgenerate

    assign bus.busy = (state_reg != IDLE);
    assign bus.done = done_reg;
    assign bus.ovf  = ovf_reg;
    assign bus.seg0 = seg_w[0];
    assign bus.seg1 = seg_w[1];
    assign bus.seg2 = seg_w[2];
    assign bus.seg3 = seg_w[3];
    assign bus.seg4 = seg_w[4];

endmodule

// File: tb/tb_pc_disp_ctrl.sv
// ----------------------------------------------------------------------------
// tb_pc_disp_ctrl
// Two instances: dut_a (AUTO_PERIOD=0) driven by directed and random update
// requests, dut_b (AUTO_PERIOD=100, upd low) for the auto-refresh cadence.
// Expected displays come from plain decimal arithmetic on pc[17:2].
// ----------------------------------------------------------------------------
module tb_pc_disp_ctrl;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    pc_disp_ctrl_if ifa ();
    pc_disp_ctrl_if ifb ();

    pc_disp_ctrl #(.AUTO_PERIOD(0)) dut_a (
        .clk (clk),
        .rst (rst),
        .bus (ifa)
    );

    pc_disp_ctrl #(.AUTO_PERIOD(100)) dut_b (
        .clk (clk),
        .rst (rst),
        .bus (ifb)
    );

    int checks = 0;
    int errors = 0;

    function automatic logic [6:0] dec_seg(input int unsigned d);
        case (d)
            0: return 7'b0000001;
            1: return 7'b1001111;
            2: return 7'b0010010;
            3: return 7'b0000110;
            4: return 7'b1001100;
            5: return 7'b0100100;
            6: return 7'b0100000;
            7: return 7'b0001111;
            8: return 7'b0000000;
            9: return 7'b0000100;
            default: return 7'b1111111;
        endcase
    endfunction

    // expected code of decimal position k of val
    function automatic logic [6:0] exp_seg(input int unsigned val, input int k);
        int unsigned p = 1;
        for (int i = 0; i < k; i++) p = p * 10;
`ifdef PCDISP_LZB_EN
        if (k > 0 && val < p) return 7'b1111111;
`endif
        return dec_seg((val / p) % 10);
    endfunction

    function automatic logic [34:0] exp_disp(input int unsigned val);
        return {exp_seg(val, 4), exp_seg(val, 3), exp_seg(val, 2),
                exp_seg(val, 1), exp_seg(val, 0)};
    endfunction

    function automatic logic [34:0] disp_a();
        return {ifa.seg4, ifa.seg3, ifa.seg2, ifa.seg1, ifa.seg0};
    endfunction

    function automatic logic [34:0] disp_b();
        return {ifb.seg4, ifb.seg3, ifb.seg2, ifb.seg1, ifb.seg0};
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick1();
        @(posedge clk);
        #1;
    endtask

    // One request from idle; pc is scrambled mid-conversion to show it
    // has no effect on the running conversion.
    task automatic conv(input logic [31:0] p, input string tag);
        int lat;
        ifa.pc  = p;
        ifa.upd = 1'b1;
        tick1();
        ifa.upd = 1'b0;
        check({tag, " busy after accept"}, ifa.busy, 1'b1);
        lat = 0;
        for (int n = 1; n <= 40; n++) begin
            tick1();
            if (ifa.done) begin
                lat = n;
                break;
            end
            if (n == 3) ifa.pc = $urandom;
        end
        check({tag, " latency"}, lat, 17);
        check({tag, " display"}, disp_a(), exp_disp(int'(p[17:2])));
        check({tag, " ovf"}, ifa.ovf, |p[31:18]);
        tick1();
        check({tag, " done one cycle"}, {ifa.done, ifa.busy}, 2'b00);
        $display("conv %-8s pc=%08h value=%0d ovf=%0b latency=%0d", tag, p, p[17:2], ifa.ovf, lat);
    endtask

    initial begin
        int dones, first, second, cnt_a, first_a, cnt_b;
        logic [31:0] p;

        rst     = 1'b1;
        ifa.pc  = '0;
        ifa.upd = 1'b0;
        ifb.pc  = 32'h0000_0010;
        ifb.upd = 1'b0;

        // ---- reset state ----
        tick1();
        tick1();
        check("rst a flags", {ifa.busy, ifa.done, ifa.ovf}, 3'b000);
        check("rst a display", disp_a(), exp_disp(0));
        check("rst b display", disp_b(), exp_disp(0));
        rst = 1'b0;
        $display("reset released");

        // ---- word 42 ----
        conv(32'h0000_00A8, "w42");
        check("w42 seg0", ifa.seg0, 7'b0010010);
        check("w42 seg1", ifa.seg1, 7'b1001100);

        // ---- maximum value, then overflow ----
        conv(32'h0003_FFFC, "max");
        conv(32'h0004_0000, "ovf");
        conv(32'hFFFC_0010, "ovf4");

        // ---- reset mid-SHIFT aborts ----
        ifa.pc  = 32'h0003_FFFC;
        ifa.upd = 1'b1;
        tick1();
        ifa.upd = 1'b0;
        for (int n = 1; n <= 9; n++) tick1();
        #2 rst = 1'b1;
        #1;
        check("abort flags", {ifa.busy, ifa.done, ifa.ovf}, 3'b000);
        check("abort display", disp_a(), exp_disp(0));
        tick1();
        rst = 1'b0;
        dones = 0;
        for (int n = 1; n <= 30; n++) begin
            tick1();
            if (ifa.done) dones++;
        end
        check("abort no done", dones, 0);
        check("abort display hold", disp_a(), exp_disp(0));
        $display("abort: dones after release=%0d", dones);

        // ---- requests during busy, pc changed mid-conversion ----
        ifa.pc  = 32'h0000_1000;      // word 1024
        ifa.upd = 1'b1;
        tick1();
        ifa.upd = 1'b0;
        dones = 0; first = 0; second = 0;
        for (int n = 1; n <= 60; n++) begin
            tick1();
            if (ifa.done) begin
                dones++;
                if (dones == 1) begin
                    first = n;
                    check("pend first display", disp_a(), exp_disp(1024));
                end else if (dones == 2) begin
                    second = n;
                    check("pend second display", disp_a(), exp_disp(4660));
                end
            end
            case (n)
                4:  begin ifa.pc = 32'h0000_48D0; ifa.upd = 1'b1; end  // word 4660
                5:  ifa.upd = 1'b0;
                9:  ifa.upd = 1'b1;
                10: ifa.upd = 1'b0;
                16: ifa.upd = 1'b1;
                17: ifa.upd = 1'b0;
                18: ifa.pc = 32'h0000_0004;
                default: ;
            endcase
        end
        check("pend first latency", first, 17);
        check("pend second latency", second, 35);
        check("pend done count", dones, 2);
        $display("pending: first=%0d second=%0d dones=%0d", first, second, dones);

        // ---- random conversions ----
        for (int i = 0; i < 10; i++) begin
            p = $urandom;
            if (i % 2 == 0) p[31:18] = '0;
            conv(p, "rand");
            for (int g = 0; g < int'($urandom_range(0, 3)); g++) tick1();
        end

        // ---- first-edge accept after reset, auto refresh ----
        rst = 1'b1;
        tick1();
        tick1();
        ifa.pc  = 32'h0000_0064;      // word 25
        ifa.upd = 1'b1;
        rst     = 1'b0;
        cnt_a = 0; first_a = 0; cnt_b = 0;
        for (int n = 1; n <= 350; n++) begin
            tick1();
            if (n == 1) ifa.upd = 1'b0;
            if (ifa.done) begin
                cnt_a++;
                if (cnt_a == 1) first_a = n;
            end
            if (ifb.done) begin
                cnt_b++;
                // tick on every 100th edge after release, done 17 later
                check("auto done timing", n, 100 * cnt_b + 17);
                check("auto display", disp_b(), exp_disp(4));
                $display("auto done at cycle %0d", n);
            end
        end
        check("first accept latency", first_a, 18);
        check("no auto in dut_a", cnt_a, 1);
        check("dut_a display", disp_a(), exp_disp(25));
        check("auto done count", cnt_b, 3);
        check("auto ovf", ifb.ovf, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
